beep_pattern_gen: RTL and testbench

BEEP_PATTERN_GEN -- requirements
Module: beep_pattern_gen

---
 rtl/beep_pattern_gen.sv | 173 +++++++++++++++++
 tb/tb_beep_pattern_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/beep_pattern_gen.sv
// ---------------------------------------------------------------------------
// beep_pattern_gen
//   Drives a buzzer or LED with a repeating ON/OFF pattern measured in ticks.
//   During ON the output is either a steady high (active buzzer / LED) or a
//   square-wave tone (passive buzzer).
//
// Ports
//   Clk        system clock, all logic on rising edge
//   Rst        synchronous, active-high reset
//   start      one-cycle request; latches on_ticks/off_ticks/repeat_n/tone_en
//   stop       abort the running pattern (wins over start)
//   on_ticks   ON phase length in ticks (0 = start ignored)
//   off_ticks  OFF phase length in ticks (0 = OFF skipped, tone continuous)
//   repeat_n   number of ON/OFF cycles, 0 = run until stopped
//              ("repeat" is a reserved word, hence the suffix)
//   tone_en    1 = square wave during ON, 0 = steady high
//   beep       registered drive output
//   busy       high while a pattern is running
//   done       one-cycle pulse on natural completion
// ---------------------------------------------------------------------------
module beep_pattern_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100,
    parameter int TONE_HZ = 2_000,
    parameter int TW      = 8,
    parameter int RW      = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          start,
    input  logic          stop,
    input  logic [TW-1:0] on_ticks,
    input  logic [TW-1:0] off_ticks,
    input  logic [RW-1:0] repeat_n,
    input  logic          tone_en,
    output logic          beep,
    output logic          busy,
    output logic          done
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int HALF     = CLK_HZ / (2 * TONE_HZ);
    // Guarded so that a bad parameter set reaches the error below instead of
    // tripping over a zero-width vector first.
    localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int HW = (HALF < 1) ? 1 : $clog2(HALF + 1);

    if (TICK_DIV < 2 || HALF < 1) begin : g_bad_params
        $error("beep_pattern_gen: TICK_DIV must be >= 2 and HALF >= 1");
    end

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;      // clocks within current tick
    logic [TW-1:0] tick_q, tick_d;        // ticks within current phase
    logic [RW-1:0] cyc_q, cyc_d;          // completed ON/OFF cycles
    logic [HW-1:0] tcnt_q, tcnt_d;        // clocks within tone half-period
    logic          tlvl_q, tlvl_d;        // current tone level
    logic [TW-1:0] on_q, on_d, off_q, off_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          tone_q, tone_d;
    logic          beep_d, done_d;

    logic [TW-1:0] phase_len;
    logic          presc_end, tick_end, tone_wrap;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = tick_q;
        cyc_d   = cyc_q;
        tcnt_d  = tcnt_q;
        tlvl_d  = tlvl_q;
        on_d    = on_q;
        off_d   = off_q;
        rep_d   = rep_q;
        tone_d  = tone_q;
        done_d  = 1'b0;

        phase_len = (state_q == ON) ? on_q : off_q;
        presc_end = (presc_q == PW'(TICK_DIV - 1));
        tick_end  = (tick_q == phase_len - 1'b1);
        tone_wrap = (tcnt_q == HW'(HALF - 1));

        if (stop) begin
            state_d = IDLE;
            presc_d = '0;
            tick_d  = '0;
            cyc_d   = '0;
            tcnt_d  = '0;
            tlvl_d  = 1'b0;
        end else if (start && on_ticks != '0) begin
            // Fresh start or retrigger: everything restarts from ON entry.
            state_d = ON;
            presc_d = '0;
            tick_d  = '0;
            cyc_d   = '0;
            tcnt_d  = '0;
            tlvl_d  = 1'b1;
            on_d    = on_ticks;
            off_d   = off_ticks;
            rep_d   = repeat_n;
            tone_d  = tone_en;
        end else if (state_q != IDLE) begin
            if (state_q == ON) begin
                tcnt_d = tone_wrap ? '0 : tcnt_q + 1'b1;
                tlvl_d = tone_wrap ? ~tlvl_q : tlvl_q;
            end
            presc_d = presc_end ? '0 : presc_q + 1'b1;
            if (presc_end) begin
                if (!tick_end) begin
                    tick_d = tick_q + 1'b1;
                end else begin
                    tick_d = '0;
                    if (state_q == ON && off_q != '0) begin
                        state_d = OFF;
                    end else if (rep_q != '0 && cyc_q == rep_q - 1'b1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Infinite mode never advances the cycle count, so it
                        // cannot wrap.
                        if (rep_q != '0)
                            cyc_d = cyc_q + 1'b1;
                        state_d = ON;
                        // ON->ON (no OFF phase) keeps the tone running
                        // seamlessly; only a real OFF restarts it high.
                        if (state_q == OFF) begin
                            tcnt_d = '0;
                            tlvl_d = 1'b1;
                        end
                    end
                end
            end
        end

        beep_d = (state_d == ON) && (tone_d ? tlvl_d : 1'b1);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            tick_q  <= '0;
            cyc_q   <= '0;
            tcnt_q  <= '0;
            tlvl_q  <= 1'b0;
            on_q    <= '0;
            off_q   <= '0;
            rep_q   <= '0;
            tone_q  <= 1'b0;
            beep    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            cyc_q   <= cyc_d;
            tcnt_q  <= tcnt_d;
            tlvl_q  <= tlvl_d;
            on_q    <= on_d;
            off_q   <= off_d;
            rep_q   <= rep_d;
            tone_q  <= tone_d;
            beep    <= beep_d;
            done    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_beep_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_beep_pattern_gen
//   Directed scenarios plus randomized starts/stops/resets. A timeline model
//   (time since start, cycle length, position within cycle) predicts beep,
//   busy and done every clock; predictions are queued and a monitor compares
//   them with the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_beep_pattern_gen;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int TONE_HZ = 100;
    localparam int TW      = 8;
    localparam int RW      = 4;
    localparam int DIV     = CLK_HZ / TICK_HZ;        // 10
    localparam int HALF    = CLK_HZ / (2 * TONE_HZ);  // 5

    logic          Clk = 1'b0;
    logic          Rst, start, stop, tone_en;
    logic [TW-1:0] on_ticks, off_ticks;
    logic [RW-1:0] repeat_n;
    logic          beep, busy, done;

    always #5 Clk = ~Clk;

    beep_pattern_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .TONE_HZ(TONE_HZ),
        .TW     (TW),
        .RW     (RW)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .start    (start),
        .stop     (stop),
        .on_ticks (on_ticks),
        .off_ticks(off_ticks),
        .repeat_n (repeat_n),
        .tone_en  (tone_en),
        .beep     (beep),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic beep;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc_no = 0;
    bit   tb_end = 0;

    bit m_act  = 0;
    int m_k    = 0;
    int m_on   = 0;
    int m_off  = 0;
    int m_rep  = 0;
    bit m_tone = 0;

    initial forever begin
        exp_t e;
        int   len, pos, tk;
        @(posedge Clk);
        cyc_no++;
        if (Rst || stop) begin
            m_act = 0;
        end else if (start && on_ticks != 0) begin
            m_act = 1; m_k = 0;
            m_on = on_ticks; m_off = off_ticks; m_rep = repeat_n; m_tone = tone_en;
        end else if (m_act) begin
            m_k++;
        end
        e = '0;
        if (m_act) begin
            len = (m_on + m_off) * DIV;
            if (m_rep != 0 && m_k >= m_rep * len) begin
                e.done = (m_k == m_rep * len);
                m_act  = 0;
            end else begin
                e.busy = 1'b1;
                pos    = m_k % len;
                if (pos < m_on * DIV) begin
                    tk     = (m_off == 0) ? m_k : pos;
                    e.beep = m_tone ? ((tk / HALF) % 2 == 0) : 1'b1;
                end
            end
        end
        sb_q.push_back(e);
    end

    initial forever begin
        exp_t e;
        @(negedge Clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_chk++;
            if ({beep, busy, done} === e)
                n_pass++;
            else
                $display("FAIL outputs cyc %0d: beep/busy/done got %b%b%b expected %b%b%b",
                         cyc_no, beep, busy, done, e.beep, e.busy, e.done);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic wait_done(input int n);
        bit seen;
        seen = 0;
        repeat (n) begin
            @(negedge Clk);
            if (done === 1'b1) seen = 1;
        end
        n_chk++;
        if (seen)
            n_pass++;
        else
            $display("FAIL timeout: done not seen within %0d cycles (cyc %0d)", n, cyc_no);
    endtask

    task automatic go(input int on, input int off, input int rep, input bit tn);
        start = 1'b1; on_ticks = TW'(on); off_ticks = TW'(off);
        repeat_n = RW'(rep); tone_en = tn;
        @(negedge Clk);
        start = 1'b0;
        on_ticks = TW'($urandom); off_ticks = TW'($urandom);
        repeat_n = RW'($urandom); tone_en = 1'($urandom);
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge Clk); stop = 1'b0;
    endtask

    task automatic pulse_rst();
        Rst = 1'b1; @(negedge Clk); Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; start = 1'b0; stop = 1'b0; tone_en = 1'b0;
        on_ticks = '0; off_ticks = '0; repeat_n = '0;
        idle(3);
        n_chk++;
        if ({beep, busy, done} === 3'b000)
            n_pass++;
        else
            $display("FAIL reset state: beep/busy/done got %b%b%b expected 000",
                     beep, busy, done);
        Rst = 1'b0;
        idle(2);

        go(2, 1, 3, 0); wait_done(100);
        go(2, 0, 1, 1); idle(30);
        go(1, 1, 0, 0); idle(499); pulse_stop(); idle(20);
        go(3, 3, 2, 0); idle(34); go(1, 1, 1, 0); idle(30);
        go(0, 2, 1, 0); idle(20);
        start = 1'b1; stop = 1'b1; on_ticks = 8'd2; off_ticks = 8'd1; repeat_n = 4'd1;
        idle(1);
        start = 1'b0; stop = 1'b0; idle(20);
        go(2, 1, 3, 0); idle(14); pulse_rst(); idle(5);
        go(2, 1, 3, 0); idle(100);
        Rst = 1'b1; start = 1'b1; on_ticks = 8'd1; repeat_n = 4'd1; idle(1);
        Rst = 1'b0; start = 1'b0; idle(10);
        go(3, 0, 2, 1); idle(70);

        for (int it = 0; it < 40; it++) begin
            go($urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom));
            for (int c = 0; c < int'($urandom_range(0, 120)); c++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 2)      pulse_stop();
                else if (r < 4) go($urandom_range(0, 3), $urandom_range(0, 3),
                                   $urandom_range(0, 3), 1'($urandom));
                else if (r < 5) pulse_rst();
                else            idle(1);
            end
        end
        pulse_stop();
        idle(5);
        tb_end = 1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
